// File: rtl/seg_scan_6.sv
// seg_scan_6: six-digit multiplexed 7-segment scanner.
// A prescaler divides clk into digit slots. Each slot begins with BLANK
// cycles of all digits off, to hide ghosting, and then lights one digit.
// The inputs are copied into a snapshot once per frame, so a frame never
// shows a mix of old and new values.
// Leading-zero suppression is available. All display outputs are
// registered and active-low.
// Optional build macro SEG_SCAN_HEX_EN: codes 10-15 are shown as A b C d E F.
// Without the macro these codes are blanked.
// Handshake note: there is no handshake. Inputs are sampled freely at each
// snapshot, and frame_tick marks the first cycle after a snapshot.
module seg_scan_6 #(
    parameter int CLK_DIV = 50000,
    parameter int BLANK   = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] digits,
    input  logic [5:0]  dp_in,
    input  logic        lz_en,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [5:0]  dig_sel,
    output logic        frame_tick
);

    localparam int            PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PRE_BLNK = PW'(BLANK);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    // Scan state
    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          load_pend;   // set by reset: the first edge loads the snapshot

    // Frame snapshot
    logic [23:0]   snap_digits;
    logic [5:0]    snap_dp;
    logic          snap_lz;

    // Next-state and next-output signals
    logic [PW-1:0] presc_nxt;
    logic [2:0]    idx_nxt;
    logic          slot_end;
    logic          capture;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [5:0]    dig_nxt;

    // Decode helpers
    logic [5:0]    nz;          // snapshot digit i is non-zero
    logic [5:1]    zero_up;     // snapshot digits i..5 are all zero
    logic [3:0]    code;
    logic          dp_req;
    logic          supp;
    logic          blank_slot;

    // BCD/hex code to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
`ifdef SEG_SCAN_HEX_EN
            4'd10:   s = 7'h08;
            4'd11:   s = 7'h03;
            4'd12:   s = 7'h46;
            4'd13:   s = 7'h21;
            4'd14:   s = 7'h06;
            4'd15:   s = 7'h0E;
`endif
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Prescaler, scan index and snapshot capture conditions
    always_comb begin
        slot_end  = (presc == PRE_LAST);
        capture   = load_pend | (slot_end & (idx == 3'd5));
        presc_nxt = presc + PRE_ONE;
        idx_nxt   = idx;
        if (load_pend || slot_end) begin
            presc_nxt = '0;
        end
        if (load_pend || idx > 3'd5) begin
            idx_nxt = 3'd0;             // unreachable 6/7 recover to slot 0
        end else if (slot_end) begin
            idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    // Leading-zero flags derived from the snapshot
    always_comb begin
        nz = '0;
        for (int i = 0; i < 6; i++) begin
            nz[i] = |snap_digits[i*4 +: 4];
        end
        zero_up[5] = ~nz[5];
        for (int i = 4; i >= 1; i--) begin
            zero_up[i] = zero_up[i+1] & ~nz[i];
        end
    end

    // Select the current digit from the snapshot and form the next outputs
    always_comb begin
        code   = 4'h0;
        dp_req = 1'b0;
        supp   = 1'b0;
        case (idx)
            3'd0: begin code = snap_digits[3:0];   dp_req = snap_dp[0]; supp = 1'b0; end
            3'd1: begin code = snap_digits[7:4];   dp_req = snap_dp[1]; supp = snap_lz & zero_up[1]; end
            3'd2: begin code = snap_digits[11:8];  dp_req = snap_dp[2]; supp = snap_lz & zero_up[2]; end
            3'd3: begin code = snap_digits[15:12]; dp_req = snap_dp[3]; supp = snap_lz & zero_up[3]; end
            3'd4: begin code = snap_digits[19:16]; dp_req = snap_dp[4]; supp = snap_lz & zero_up[4]; end
            3'd5: begin code = snap_digits[23:20]; dp_req = snap_dp[5]; supp = snap_lz & zero_up[5]; end
            default: begin code = 4'h0; dp_req = 1'b0; supp = 1'b1; end
        endcase

        blank_slot = (presc < PRE_BLNK) || (idx > 3'd5);
        seg_nxt    = 7'h7F;
        dp_nxt     = 1'b1;
        dig_nxt    = 6'h3F;
        if (!blank_slot) begin
            // A suppressed digit keeps its enable; only segments and dp go dark
            dig_nxt = ~(6'b000001 << idx);
            if (!supp) begin
                seg_nxt = decode(code);
                dp_nxt  = ~dp_req;
            end
        end
    end

    // Scan counters, snapshot and start-up load flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            idx         <= 3'd0;
            load_pend   <= 1'b1;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_lz     <= 1'b0;
        end else begin
            presc     <= presc_nxt;
            idx       <= idx_nxt;
            load_pend <= 1'b0;
            if (capture) begin
                snap_digits <= digits;
                snap_dp     <= dp_in;
                snap_lz     <= lz_en;
            end
        end
    end

    // Registered display outputs and frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out    <= 7'h7F;
            dp_out     <= 1'b1;
            dig_sel    <= 6'h3F;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_nxt;
            dp_out     <= dp_nxt;
            dig_sel    <= dig_nxt;
            frame_tick <= capture;
        end
    end

endmodule

// File: doc/seg_scan_6.md
SEG_SCAN_6 -- requirements
Module: seg_scan_6

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clk cycles per digit slot; legal range 4..2^20.
REQ-002 SHALL have parameter BLANK, default 500, clk cycles at slot start with all digits off; legal range 1..CLK_DIV-1.
REQ-003 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port digits  input  24  six BCD digits from the counter chain; [3:0]=digit0 (rightmost) .. [23:20]=digit5.
REQ-006 SHALL have port dp_in  input  6  decimal point request per digit, 1=lit; bit i = digit i.
REQ-007 SHALL have port lz_en  input  1  1=leading-zero suppression on.
REQ-008 SHALL have port seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 SHALL have port dp_out  output  1  decimal point, active-low, registered.
REQ-010 SHALL have port dig_sel  output  6  digit enables, active-low, one-cold at most, registered.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at each frame start.

Function
REQ-012 SHALL run a prescaler counting 0..CLK_DIV-1 and wrapping; the wrap cycle is the slot end.
REQ-013 SHALL advance a 3-bit scan index 0,1,2,3,4,5,0 at each slot end; values 6-7 are unreachable and force index 0 next cycle.
REQ-014 SHALL capture digits, dp_in and lz_en into a snapshot on the cycle index moves 5->0; all six slots of a frame display that snapshot, so there is no tearing.
REQ-015 SHALL pulse frame_tick high for exactly the one cycle after the snapshot capture.
REQ-016 SHALL drive dig_sel = 6'h3F while prescaler < BLANK; otherwise it SHALL drive only bit[index] low.
REQ-017 SHALL drive seg_out and dp_out for digit[index] of the snapshot with the same registered latency as dig_sel, giving 1-cycle latency from index/prescaler state.
REQ-018 SHALL decode codes 0-9 as: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, active-low).
REQ-019 SHALL handle codes 10-15 as defined by the Configuration section.
REQ-020 SHALL blank (seg_out=7F, dp_out=1) digit i, for i=5..1, when snapshot lz_en=1 and snapshot digits i..5 are all 0; digit0 is never suppressed.
REQ-021 SHALL leave a suppressed digit's dig_sel behaviour unchanged and SHALL suppress its dp as well.
REQ-022 SHALL not let input changes mid-frame affect outputs before the next snapshot.

Reset
REQ-023 SHALL, while reset=1, immediately set prescaler=0, index=0, snapshot=0, seg_out=7F, dp_out=1, dig_sel=3F and frame_tick=0.
REQ-024 SHALL, on the first edge after reset release, load the snapshot from the inputs, pulse frame_tick and begin slot 0 with prescaler=0.
REQ-025 SHALL, on a reset asserted mid-slot, blank all outputs within the same cycle with no glitch to a lit digit.

Configuration
REQ-026 SHALL, with macro SEG_SCAN_HEX_EN defined, decode codes 10-15 as A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-027 SHALL, without SEG_SCAN_HEX_EN, decode codes 10-15 as blank (7F); leading-zero logic treats them as non-zero.

Verification (CLK_DIV=8, BLANK=2)
REQ-028 SHALL check: reset held 5 cycles -> dig_sel=3F, seg_out=7F, dp_out=1, frame_tick=0 throughout.
REQ-029 SHALL check: digits=24'h012345, lz_en=0 -> per slot, 2 blank cycles then 6 lit; slot0 dig_sel=3E with seg_out=12, slot5 dig_sel=1F with seg_out=40; frame_tick every 48 cycles.
REQ-030 SHALL check: digits=24'h000705, lz_en=1, dp_in=6'b000100 -> digits 5,4,3 blank; digit2 seg_out=78, dp_out=0; digit0 seg_out=12.
REQ-031 SHALL check: digits changed from 24'h000000 to 24'h999999 during slot 2 -> remaining slots still show 40; next frame shows 10 on all digits.
REQ-032 SHALL check: digits[3:0]=4'hA -> seg_out=08 with SEG_SCAN_HEX_EN defined, 7F without.
REQ-033 SHALL check: reset pulsed mid slot 3 -> outputs blank asynchronously; after release, frame_tick is seen and slot 0 restarts.
